// File: rtl/rom_page_ctrl.sv
// rom_page_ctrl: chooses which program ROM page feeds the core's instruction
// bus and performs page switches safely. A switch overrides the bus with
// BRANCH 0 until the core's PC is back at 0, then commits the new page. A core
// that never reaches PC 0 within WAIT_MAX flush cycles parks the controller in
// a sticky error state that only reset clears.
module rom_page_ctrl #(
  parameter int                   INSTR_LEN  = 8,
  parameter int                   PC_LEN     = 7,
  parameter int                   NPAGES     = 4,
  parameter int                   PAGE_W     = 2,
  parameter logic [INSTR_LEN-1:0] BRANCH0    = 'h80,
  parameter int                   WAIT_MAX   = 4,
  parameter int                   RESET_PAGE = 0
) (
  input  logic                        CLK,
  input  logic                        RSTN,
  input  logic [PC_LEN-1:0]           PC,
  input  logic [NPAGES*INSTR_LEN-1:0] rom_data,
  input  logic                        req_valid,
  input  logic [PAGE_W-1:0]           req_page,
  output logic                        req_ready,
  output logic [INSTR_LEN-1:0]        INSTR,
  output logic [PAGE_W-1:0]           cur_page,
  output logic                        switching,
  output logic                        done,
  output logic                        err
);

  localparam int                WAIT_W    = $clog2(WAIT_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_ERROR = 2'd2;

  logic [1:0]           state;
  logic [PAGE_W-1:0]    pend_page;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [INSTR_LEN-1:0] page_word;

  // Select the committed page's word at the current PC.
  always_comb begin
    // NOTE: default first so every path assigns page_word and no latch is inferred.
    page_word = '0;
    for (int p = 0; p < NPAGES; p++) begin
      if (int'(cur_page) == p) page_word = rom_data[p*INSTR_LEN +: INSTR_LEN];
    end
  end

  // Instruction bus and handshake flags are decoded only from state, so there
  // is no combinational path from req_valid to any output.
  always_comb begin
    INSTR     = (state == ST_IDLE) ? page_word : BRANCH0;
    req_ready = (state == ST_IDLE);
    switching = (state == ST_FLUSH);
  end

  // Page-switch FSM: accept in IDLE, wait for PC 0 in FLUSH, park in ERROR.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= ST_IDLE;
      cur_page  <= PAGE_W'(RESET_PAGE);
      pend_page <= '0;
      wait_cnt  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            // Out-of-range requests wrap around the page count.
            pend_page <= PAGE_W'(int'(req_page) % NPAGES);
            wait_cnt  <= '0;
            state     <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (PC == '0) begin
            cur_page <= pend_page;
            done     <= 1'b1;
            state    <= ST_IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            err   <= 1'b1;
            state <= ST_ERROR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_ERROR: state <= ST_ERROR;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_page_ctrl.sv
// Bench for rom_page_ctrl. A small core model drives PC (it jumps to 0 when it
// sees BRANCH 0 on the bus, otherwise steps or holds). Each accepted request
// pushes the commit the bench expects; a monitor pops it when done pulses and
// checks page, bus word, latency and the number of BRANCH 0 words issued.
// A second instance with two pages shares all inputs to exercise page wrap.
module tb_rom_page_ctrl;

  localparam logic [7:0] BR0 = 8'h80;

  typedef struct {
    int page;
    int acc;
    int lat;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic [6:0]  PC;
  logic [31:0] rom_data;
  logic [15:0] rom_data2;
  logic        req_valid;
  logic [1:0]  req_page;
  logic        req_ready, req_ready2;
  logic [7:0]  INSTR, INSTR2;
  logic [1:0]  cur_page, cur_page2;
  logic        switching, switching2;
  logic        done, done2;
  logic        err, err2;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   flush_cnt = 0;
  int   model_page = 0;
  exp_t q[$];

  logic       core_run;
  logic       acc_flag;
  logic [6:0] acc_pc;
  int         acc_cyc;

  rom_page_ctrl dut (
    .CLK(CLK), .RSTN(RSTN), .PC(PC), .rom_data(rom_data),
    .req_valid(req_valid), .req_page(req_page), .req_ready(req_ready),
    .INSTR(INSTR), .cur_page(cur_page), .switching(switching),
    .done(done), .err(err)
  );

  rom_page_ctrl #(.NPAGES(2), .PAGE_W(2)) dut2 (
    .CLK(CLK), .RSTN(RSTN), .PC(PC), .rom_data(rom_data2),
    .req_valid(req_valid), .req_page(req_page), .req_ready(req_ready2),
    .INSTR(INSTR2), .cur_page(cur_page2), .switching(switching2),
    .done(done2), .err(err2)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  // ROM contents: bit 7 clear so no page word is ever mistaken for BRANCH 0.
  function automatic logic [7:0] rom_word(int p, logic [6:0] pc);
    logic [1:0] pp;
    pp = p[1:0];
    return {1'b0, pp, pc[4:0]};
  endfunction

  always_comb begin
    rom_data = '0;
    for (int p = 0; p < 4; p++) rom_data[p*8 +: 8] = rom_word(p, PC);
    rom_data2 = rom_data[15:0];
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge CLK) begin
    exp_t e;
    if (!RSTN) begin
      flush_cnt = 0;
    end else begin
      if (INSTR == BR0 && !err) flush_cnt++;
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", done, 1'b0);
        end else begin
          e = q.pop_front();
          check("commit_page",   cur_page,  e.page % 4);
          check("commit_page2",  cur_page2, e.page % 2);
          check("commit_done2",  done2, 1'b1);
          check("done_vs_switch", switching, 1'b0);
          check("commit_instr",  INSTR,  rom_word(e.page % 4, PC));
          check("commit_instr2", INSTR2, rom_word(e.page % 2, PC));
          check("commit_latency", cyc - e.acc, e.lat);
          check("branch0_count", flush_cnt, e.lat);
          flush_cnt = 0;
        end
      end
    end
  end

  // One clock of the core model; records whether this edge accepted a request.
  task automatic tick();
    logic [7:0] ins;
    @(negedge CLK);
    ins      = INSTR;
    acc_flag = req_valid && req_ready;
    acc_pc   = PC;
    acc_cyc  = cyc + 1;
    @(posedge CLK);
    #1;
    if (core_run) PC = (ins == BR0) ? 7'd0 : PC + 7'd1;
  endtask

  // A core stepping normally is at PC+1 on the first flush edge; a held core
  // stays put. Commit comes on that edge if PC is 0 there, else one later.
  task automatic request(int page, bit expect_commit);
    bit         got;
    logic [6:0] nxt;
    got       = 1'b0;
    req_page  = page[1:0];
    req_valid = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (acc_flag) got = 1'b1;
    end
    req_valid = 1'b0;
    check("request_accepted", got, 1'b1);
    if (got && expect_commit) begin
      nxt = core_run ? acc_pc + 7'd1 : acc_pc;
      q.push_back('{page, acc_cyc, (nxt == 7'd0) ? 1 : 2});
      model_page = page;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 12 && q.size() != 0; i++) tick();
    if (q.size() != 0) begin
      check("commit_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic reset_checks(string tag);
    check({tag, "_cur_page"},  cur_page, 2'd0);
    check({tag, "_cur_page2"}, cur_page2, 2'd0);
    check({tag, "_ready"},     req_ready, 1'b1);
    check({tag, "_err"},       err, 1'b0);
    check({tag, "_switching"}, switching, 1'b0);
    check({tag, "_done"},      done, 1'b0);
    check({tag, "_instr"},     INSTR, rom_word(0, PC));
  endtask

  task automatic do_reset(string tag);
    @(posedge CLK);
    #2;
    RSTN = 1'b0;
    q.delete();
    #1;
    reset_checks(tag);
    @(negedge CLK);
    @(posedge CLK);
    #1;
    RSTN = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    RSTN      = 1'b0;
    PC        = 7'd5;
    req_valid = 1'b0;
    req_page  = 2'd0;
    core_run  = 1'b0;
    #3;
    reset_checks("reset");
    #20;
    @(negedge CLK);
    RSTN = 1'b1;
    tick();

    // Normal switch from a nonzero PC: 2-cycle latency.
    PC = 7'h12;
    core_run = 1'b1;
    request(1, 1'b1);
    wait_idle();

    // PC already 0 and held: commit on the first flush edge, one BRANCH 0.
    core_run = 1'b0;
    PC = 7'd0;
    request(2, 1'b1);
    wait_idle();

    // A request raised during a flush is ignored, then accepted from IDLE.
    core_run = 1'b1;
    PC = 7'h30;
    request(1, 1'b1);
    req_page  = 2'd2;
    req_valid = 1'b1;
    tick();
    check("flush_ignores_req", acc_flag, 1'b0);
    req_valid = 1'b0;
    wait_idle();
    request(2, 1'b1);
    wait_idle();

    // Randomized switches, including PC at 0 and at the wrap point 127.
    repeat (40) begin
      r = $urandom_range(0, 9);
      PC = (r == 0) ? 7'd0 : (r == 1) ? 7'd127 : 7'($urandom_range(0, 127));
      request($urandom_range(0, 3), 1'b1);
      wait_idle();
      repeat ($urandom_range(0, 3)) tick();
    end

    // Core stuck at PC 3: four flush cycles, then sticky error.
    core_run = 1'b0;
    PC = 7'd3;
    request(2, 1'b0);
    repeat (4) begin
      @(negedge CLK);
      check("stuck_switching", switching, 1'b1);
      check("stuck_no_err", err, 1'b0);
    end
    @(negedge CLK);
    check("err_set",       err, 1'b1);
    check("err2_set",      err2, 1'b1);
    check("err_switching", switching, 1'b0);
    check("err_ready",     req_ready, 1'b0);
    check("err_instr",     INSTR, BR0);
    check("err_keep_page", cur_page, model_page % 4);
    repeat (3) begin
      @(negedge CLK);
      check("err_sticky", err, 1'b1);
    end
    do_reset("err_reset");

    // Reset in the middle of a flush toward page 3 discards the switch.
    core_run = 1'b1;
    PC = 7'h05;
    request(1, 1'b1);
    wait_idle();
    PC = 7'h20;
    request(3, 1'b1);
    do_reset("midflush_reset");
    repeat (4) tick();
    check("after_reset_page",  cur_page, 2'd0);
    check("after_reset_page2", cur_page2, 2'd0);

    // Page 3 on the two-page instance wraps to page 1.
    PC = 7'h40;
    request(3, 1'b1);
    wait_idle();

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
